// File: rtl/freq_meas_ctrl.sv
// Sequencer/checker around freq_meas: fires the window-start enable, waits out window
// plus CDC settle, captures a stable count and reports limit/alarm status.
module freq_meas_ctrl #(
  parameter int WINDOW_CYCLES = 100000,
  parameter int SETTLE_CYCLES = 64,
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MAX_RETRY     = 8,
  parameter int ALARM_CONSEC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        start,
  input  logic [23:0] lo_limit,
  input  logic [23:0] hi_limit,
  input  logic        alarm_clear,
  output logic        fmeas_enable,
  input  logic [23:0] fmeas_count,
  output logic [23:0] meas_count,
  output logic        meas_valid,
  output logic        in_range,
  output logic        stuck_zero,
  output logic        stuck_ones,
  output logic        alarm,
  output logic        sample_err,
  output logic        busy
);

  localparam int WAIT_LOAD = WINDOW_CYCLES + SETTLE_CYCLES;
  localparam int WAIT_W    = $clog2(WAIT_LOAD + 1);
  localparam int PER_W     = $clog2(PERIOD_CYCLES + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam int CONSEC_W  = $clog2(ALARM_CONSEC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_SAMPLE, S_CHECK, S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic [23:0]         samp_q, samp_d;
  logic [23:0]         meas_count_q, meas_count_d;
  logic                fmeas_enable_q, fmeas_enable_d;
  logic                meas_valid_q, meas_valid_d;
  logic                in_range_q, in_range_d;
  logic                stuck_zero_q, stuck_zero_d;
  logic                stuck_ones_q, stuck_ones_d;
  logic                alarm_q, alarm_d;
  logic                sample_err_q, sample_err_d;
  logic                busy_q, busy_d;
  logic                out_of_range;

  // An inverted window (lo > hi) makes every value fail here, so in_range stays 0.
  assign out_of_range = (fmeas_count < lo_limit) || (fmeas_count > hi_limit);

  always_comb begin
    // NOTE: every _d starts from its _q (or a safe default) so no path infers a latch.
    state_d      = state_q;
    wait_d       = wait_q;
    period_d     = (period_q != '0) ? period_q - 1'b1 : '0;
    retry_d      = retry_q;
    consec_d     = consec_q;
    samp_d       = fmeas_count;
    meas_count_d = meas_count_q;
    in_range_d   = in_range_q;
    stuck_zero_d = stuck_zero_q;
    stuck_ones_d = stuck_ones_q;
    alarm_d      = alarm_clear ? 1'b0 : alarm_q;
    sample_err_d = alarm_clear ? 1'b0 : sample_err_q;

    case (state_q)
      S_IDLE: if (start || run) state_d = S_ARM;
      S_ARM: begin
        wait_d   = WAIT_W'(WAIT_LOAD);
        period_d = PER_W'(PERIOD_CYCLES - 1);
        retry_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= WAIT_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (fmeas_count == samp_q) begin
          state_d      = S_CHECK;
          meas_count_d = fmeas_count;
          in_range_d   = !out_of_range;
          stuck_zero_d = (fmeas_count == 24'h000000);
          stuck_ones_d = (fmeas_count == 24'hFFFFFF);
          if (out_of_range) begin
            consec_d = (consec_q == CONSEC_W'(ALARM_CONSEC)) ? consec_q : consec_q + 1'b1;
            if (consec_d == CONSEC_W'(ALARM_CONSEC)) alarm_d = 1'b1;
          end else begin
            consec_d = '0;
          end
        end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
          sample_err_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      S_CHECK: state_d = S_HOLD;
      S_HOLD: begin
        if (!run)                 state_d = S_IDLE;
        else if (period_d == '0)  state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes and busy are registered off the next state so they line up with it.
    fmeas_enable_d = (state_d == S_ARM);
    meas_valid_d   = (state_d == S_CHECK);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      period_q       <= '0;
      retry_q        <= '0;
      consec_q       <= '0;
      samp_q         <= '0;
      meas_count_q   <= '0;
      fmeas_enable_q <= 1'b0;
      meas_valid_q   <= 1'b0;
      in_range_q     <= 1'b0;
      stuck_zero_q   <= 1'b0;
      stuck_ones_q   <= 1'b0;
      alarm_q        <= 1'b0;
      sample_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      period_q       <= period_d;
      retry_q        <= retry_d;
      consec_q       <= consec_d;
      samp_q         <= samp_d;
      meas_count_q   <= meas_count_d;
      fmeas_enable_q <= fmeas_enable_d;
      meas_valid_q   <= meas_valid_d;
      in_range_q     <= in_range_d;
      stuck_zero_q   <= stuck_zero_d;
      stuck_ones_q   <= stuck_ones_d;
      alarm_q        <= alarm_d;
      sample_err_q   <= sample_err_d;
      busy_q         <= busy_d;
    end
  end

  assign fmeas_enable = fmeas_enable_q;
  assign meas_count   = meas_count_q;
  assign meas_valid   = meas_valid_q;
  assign in_range     = in_range_q;
  assign stuck_zero   = stuck_zero_q;
  assign stuck_ones   = stuck_ones_q;
  assign alarm        = alarm_q;
  assign sample_err   = sample_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: table vectors, hand-written corner sequences
// and randomized single shots against a history-based reference model.
module tb_freq_meas_ctrl;

  localparam int W   = 100;
  localparam int S   = 8;
  localparam int P   = 300;
  localparam int MR  = 4;
  localparam int AC  = 2;
  localparam int LAT = W + S + 2;

  logic        clk = 1'b0;
  logic        reset, run, start, alarm_clear;
  logic [23:0] lo_limit, hi_limit, fmeas_count;
  logic        fmeas_enable, meas_valid, in_range, stuck_zero, stuck_ones;
  logic        alarm, sample_err, busy;
  logic [23:0] meas_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] obs_count;
  logic        obs_in, obs_z, obs_o, obs_al;

  freq_meas_ctrl #(
    .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .PERIOD_CYCLES(P),
    .MAX_RETRY(MR), .ALARM_CONSEC(AC)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .start(start),
    .lo_limit(lo_limit), .hi_limit(hi_limit), .alarm_clear(alarm_clear),
    .fmeas_enable(fmeas_enable), .fmeas_count(fmeas_count),
    .meas_count(meas_count), .meas_valid(meas_valid), .in_range(in_range),
    .stuck_zero(stuck_zero), .stuck_ones(stuck_ones), .alarm(alarm),
    .sample_err(sample_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cnt, lo, hi;
    bit clr;
    bit e_in, e_z, e_o, e_al;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] c, input logic [23:0] l, input logic [23:0] h,
                              input bit clr, input bit ei, input bit ez, input bit eo, input bit ea);
    vec_t v;
    v.cnt = c; v.lo = l; v.hi = h; v.clr = clr;
    v.e_in = ei; v.e_z = ez; v.e_o = eo; v.e_al = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One single-shot measurement with a stable count; captures outputs at the strobe.
  task automatic measure(input logic [23:0] cnt, input logic [23:0] lo, input logic [23:0] hi,
                         input string tag);
    int en_n, t_arm, t_val;
    bit got;
    fmeas_count = cnt; lo_limit = lo; hi_limit = hi;
    start = 1'b1;
    tick();
    start = 1'b0;
    en_n = 0; t_arm = -1; t_val = -1000; got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (fmeas_enable) begin
        en_n++;
        if (t_arm < 0) t_arm = k;
      end
      if (meas_valid) begin
        got = 1'b1; t_val = k;
        obs_count = meas_count; obs_in = in_range; obs_z = stuck_zero;
        obs_o = stuck_ones; obs_al = alarm;
        break;
      end
      tick();
    end
    check({tag, " valid_seen"}, got, 1);
    check({tag, " enable_width"}, en_n, 1);
    check({tag, " latency"}, t_val - t_arm, LAT);
    for (int k = 0; k < 5 && busy; k++) tick();
    check({tag, " back_to_idle"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[14];
    int   n_en, n_v, t_err, n_tail_en;
    int   en_t[$];
    bit   hist[$];
    bit   m_alarm, exp_in, all_out;
    logic [23:0] cnt, lo, hi;

    reset = 1'b1; run = 1'b0; start = 1'b0; alarm_clear = 1'b0;
    lo_limit = 24'd4000; hi_limit = 24'd6000; fmeas_count = 24'd0;
    do_reset();
    check("reset flags", {fmeas_enable, meas_valid, in_range, stuck_zero, stuck_ones,
                          alarm, sample_err, busy}, 0);
    check("reset meas_count", meas_count, 0);

    // ---------- table-driven vectors (limits 4000..6000 unless noted) ----------
    vecs[0]  = mk(24'd5000,    24'd4000, 24'd6000, 0, 1, 0, 0, 0);
    vecs[1]  = mk(24'd7000,    24'd4000, 24'd6000, 0, 0, 0, 0, 0);
    vecs[2]  = mk(24'd5000,    24'd4000, 24'd6000, 0, 1, 0, 0, 0);
    vecs[3]  = mk(24'd7000,    24'd4000, 24'd6000, 0, 0, 0, 0, 0);
    vecs[4]  = mk(24'd7000,    24'd4000, 24'd6000, 0, 0, 0, 0, 1);
    vecs[5]  = mk(24'd7000,    24'd4000, 24'd6000, 1, 0, 0, 0, 1);
    vecs[6]  = mk(24'd0,       24'd4000, 24'd6000, 0, 0, 1, 0, 1);
    vecs[7]  = mk(24'hFFFFFF,  24'd4000, 24'd6000, 0, 0, 0, 1, 1);
    vecs[8]  = mk(24'd4000,    24'd4000, 24'd6000, 0, 1, 0, 0, 1);
    vecs[9]  = mk(24'd6000,    24'd4000, 24'd6000, 0, 1, 0, 0, 1);
    vecs[10] = mk(24'd3999,    24'd4000, 24'd6000, 1, 0, 0, 0, 0);
    vecs[11] = mk(24'd6001,    24'd4000, 24'd6000, 0, 0, 0, 0, 1);
    vecs[12] = mk(24'd5000,    24'd6000, 24'd4000, 0, 0, 0, 0, 1);
    vecs[13] = mk(24'd5000,    24'd5000, 24'd5000, 0, 1, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].clr) begin
        pulse_clear();
        check($sformatf("v%0d alarm_after_clear", i), alarm, 0);
      end
      measure(vecs[i].cnt, vecs[i].lo, vecs[i].hi, $sformatf("v%0d", i));
      check($sformatf("v%0d meas_count", i), obs_count, vecs[i].cnt);
      check($sformatf("v%0d in_range", i), obs_in, vecs[i].e_in);
      check($sformatf("v%0d stuck_zero", i), obs_z, vecs[i].e_z);
      check($sformatf("v%0d stuck_ones", i), obs_o, vecs[i].e_o);
      check($sformatf("v%0d alarm", i), obs_al, vecs[i].e_al);
    end

    // ---------- reset mid-WAIT: no partial result, everything cleared ----------
    fmeas_count = 24'd5000; lo_limit = 24'd4000; hi_limit = 24'd6000;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    check("midwait busy_before_reset", busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midwait reset flags", {fmeas_enable, meas_valid, in_range, stuck_zero, stuck_ones,
                                  alarm, sample_err, busy}, 0);
    check("midwait reset meas_count", meas_count, 0);
    n_v = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (meas_valid || fmeas_enable) n_v++;
    end
    check("midwait no_activity_after_reset", n_v, 0);

    // ---------- start while busy is ignored ----------
    start = 1'b1; tick(); start = 1'b0;
    n_en = fmeas_enable ? 1 : 0; n_v = 0;
    for (int k = 0; k < 250; k++) begin
      start = (k == 20);
      tick();
      if (fmeas_enable) n_en++;
      if (meas_valid) n_v++;
    end
    start = 1'b0;
    check("busy_start enables", n_en, 1);
    check("busy_start valids", n_v, 1);
    check("busy_start meas_count", meas_count, 24'd5000);

    // ---------- unstable count through SAMPLE ----------
    fmeas_count = 24'h000100;
    start = 1'b1; tick(); start = 1'b0;
    n_v = 0; t_err = -1;
    for (int k = 1; k < 160; k++) begin
      fmeas_count = fmeas_count ^ 24'h000001;
      tick();
      if (meas_valid) n_v++;
      if (sample_err && t_err < 0) t_err = k;
    end
    check("unstable valids", n_v, 0);
    check("unstable sample_err_time", t_err, W + S + 1 + MR);
    check("unstable sample_err", sample_err, 1);
    check("unstable meas_count_held", meas_count, 24'd5000);
    check("unstable idle", busy, 0);
    pulse_clear();
    check("unstable sample_err_cleared", sample_err, 0);

    // ---------- run mode period ----------
    fmeas_count = 24'd5000; lo_limit = 24'd4000; hi_limit = 24'd6000;
    run = 1'b1; n_v = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (fmeas_enable) en_t.push_back(k);
      if (meas_valid) n_v++;
    end
    run = 1'b0; n_tail_en = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      tick();
      if (fmeas_enable) n_tail_en++;
      if (meas_valid) n_v++;
    end
    check("run enables", en_t.size(), 4);
    for (int i = 1; i < en_t.size(); i++)
      check($sformatf("run gap%0d", i), en_t[i] - en_t[i-1], P);
    check("run tail_enables", n_tail_en, 0);
    check("run valids", n_v, 4);
    check("run idle", busy, 0);

    // ---------- randomized single shots vs history model ----------
    do_reset();
    check("rand reset alarm", alarm, 0);
    m_alarm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lo = 24'($urandom_range(1000, 9000));
      hi = 24'(int'(lo) + int'($urandom_range(0, 3000)) - 500);
      case ($urandom_range(0, 5))
        0: cnt = 24'd0;
        1: cnt = 24'hFFFFFF;
        2: cnt = lo;
        3: cnt = hi;
        4: cnt = lo + 24'($urandom_range(0, 6)) - 24'd3;
        default: cnt = 24'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        pulse_clear();
        m_alarm = 1'b0;
      end
      exp_in = (lo <= cnt) && (cnt <= hi);
      hist.push_back(!exp_in);
      if (hist.size() > AC) void'(hist.pop_front());
      all_out = (hist.size() == AC);
      foreach (hist[j]) if (!hist[j]) all_out = 1'b0;
      if (all_out) m_alarm = 1'b1;
      measure(cnt, lo, hi, $sformatf("r%0d", i));
      check($sformatf("r%0d meas_count", i), obs_count, cnt);
      check($sformatf("r%0d in_range", i), obs_in, exp_in);
      check($sformatf("r%0d stuck_zero", i), obs_z, cnt == 24'd0);
      check($sformatf("r%0d stuck_ones", i), obs_o, cnt == 24'hFFFFFF);
      check($sformatf("r%0d alarm", i), obs_al, m_alarm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
